// File: rtl/ud_counter_param.sv
// ud_counter_param: parametrised up/down counter with range 0..MAX.
// Supports synchronous load, wrap or saturate at the boundaries, a combinational
// terminal-count look-ahead and registered one-cycle overflow/underflow pulses.
module ud_counter_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             E,
    input  logic             U,
    input  logic             Ld,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Cnt,
    output logic             Tc,
    output logic             Ovf,
    output logic             Unf
);

    // Reject a terminal count that does not fit in the counter width.
    if (WIDTH < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_max
        $error("ud_counter_param: MAX does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == MaxV);
    assign at_zero = (cnt_q == '0);

    // Next-state: load beats counting; boundary steps wrap or hold and raise an event.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (Ld) begin
            // Clamp out-of-range load values so the count never leaves 0..MAX.
            cnt_d = (D > MaxV) ? MaxV : D;
        end else if (E) begin
            if (U) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    cnt_d = SATURATE ? MaxV : '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    unf_d = 1'b1;
                    cnt_d = SATURATE ? '0 : MaxV;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Terminal count predicts the event pulse of the coming edge; deliberately not gated by Rst.
    assign Tc  = E & ~Ld & ((U & at_max) | (~U & at_zero));
    assign Cnt = cnt_q;
    assign Ovf = ovf_q;
    assign Unf = unf_q;

endmodule

// File: tb/tb_ud_counter_param.sv
// Bench for ud_counter_param: three instances (modulo-16 wrap, decade wrap,
// decade saturate) each checked against a reference model through a scoreboard.
module tb_ud_counter_param;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
        logic       tc;
    } exp_t;

    typedef struct packed {
        bit       r;
        bit       l;
        bit       e;
        bit       u;
        logic [3:0] d;
    } stim_t;

    logic       clk;
    logic       rst [3];
    logic       e   [3];
    logic       u   [3];
    logic       ld  [3];
    logic [3:0] d   [3];
    logic [3:0] cnt [3];
    logic       tc  [3];
    logic       ovf [3];
    logic       unf [3];

    int   checks;
    int   errors;
    int   m_cnt [3];
    exp_t sb [$];

    ud_counter_param #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u_wrap16 (
        .Clk(clk), .Rst(rst[0]), .E(e[0]), .U(u[0]), .Ld(ld[0]), .D(d[0]),
        .Cnt(cnt[0]), .Tc(tc[0]), .Ovf(ovf[0]), .Unf(unf[0])
    );

    ud_counter_param #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_dec_wrap (
        .Clk(clk), .Rst(rst[1]), .E(e[1]), .U(u[1]), .Ld(ld[1]), .D(d[1]),
        .Cnt(cnt[1]), .Tc(tc[1]), .Ovf(ovf[1]), .Unf(unf[1])
    );

    ud_counter_param #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_dec_sat (
        .Clk(clk), .Rst(rst[2]), .E(e[2]), .U(u[2]), .Ld(ld[2]), .D(d[2]),
        .Cnt(cnt[2]), .Tc(tc[2]), .Ovf(ovf[2]), .Unf(unf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int max_of(input int k);
        return (k == 0) ? 15 : 9;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 2);
    endfunction

    function automatic stim_t st(input bit r, input bit l, input bit en, input bit up,
                                 input logic [3:0] dv);
        stim_t s;
        s.r = r; s.l = l; s.e = en; s.u = up; s.d = dv;
        return s;
    endfunction

    // Apply one cycle of stimulus to instance k at the falling edge, other instances hold.
    // The model advances here and the expected result is queued for the next rising edge.
    task automatic drive(input int k, input stim_t s);
        exp_t x;
        int   mx;
        mx = max_of(k);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            if (j != k) begin
                e[j]  = 1'b0;
                ld[j] = 1'b0;
            end
        end
        rst[k] = s.r; ld[k] = s.l; e[k] = s.e; u[k] = s.u; d[k] = s.d;
        x.tc  = s.e && !s.l && ((s.u && m_cnt[k] == mx) || (!s.u && m_cnt[k] == 0));
        x.ovf = 1'b0;
        x.unf = 1'b0;
        if (s.r) begin
            m_cnt[k] = 0;
        end else if (s.l) begin
            m_cnt[k] = (int'(s.d) > mx) ? mx : int'(s.d);
        end else if (s.e && s.u) begin
            if (m_cnt[k] == mx) begin
                x.ovf = 1'b1;
                if (!sat_of(k)) m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end else if (s.e) begin
            if (m_cnt[k] == 0) begin
                x.unf = 1'b1;
                if (!sat_of(k)) m_cnt[k] = mx;
            end else begin
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
        x.cnt = 4'(m_cnt[k]);
        sb.push_back(x);
    endtask

    task automatic test_reset();
        exp_t  x;
        stim_t q [$];
        for (int k = 0; k < 3; k++) begin
            q = '{};
            q.push_back(st(1, 0, 0, 0, 4'd0));
            q.push_back(st(1, 0, 0, 0, 4'd0));
            q.push_back(st(1, 0, 1, 0, 4'd0)); // Tc visible while still in reset
            q.push_back(st(1, 1, 1, 1, 4'd7)); // reset overrides load/enable
            foreach (q[i]) begin
                drive(k, q[i]);
                #1;
                checks++;
                if (tc[k] !== sb[0].tc) begin
                    errors++;
                    $display("FAIL reset tc inst%0d step%0d: got %b want %b", k, i, tc[k], sb[0].tc);
                end
                @(posedge clk); #1;
                x = sb.pop_front();
                checks++;
                if (cnt[k] !== x.cnt || ovf[k] !== x.ovf || unf[k] !== x.unf) begin
                    errors++;
                    $display("FAIL reset state inst%0d step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                             k, i, cnt[k], ovf[k], unf[k], x.cnt, x.ovf, x.unf);
                end
            end
        end
    endtask

    // Up then down around the full modulo-16 range; exactly one event each way.
    task automatic test_wrap();
        exp_t  x;
        stim_t q [$];
        int    n_ovf, n_unf;
        n_ovf = 0; n_unf = 0;
        for (int i = 0; i < 20; i++) q.push_back(st(0, 0, 1, 1, 4'd0));
        for (int i = 0; i < 17; i++) q.push_back(st(0, 0, 1, 0, 4'd0));
        foreach (q[i]) begin
            drive(0, q[i]);
            #1;
            checks++;
            if (tc[0] !== sb[0].tc) begin
                errors++;
                $display("FAIL wrap tc step%0d: got %b want %b", i, tc[0], sb[0].tc);
            end
            @(posedge clk); #1;
            x = sb.pop_front();
            n_ovf += int'(ovf[0]);
            n_unf += int'(unf[0]);
            checks++;
            if (cnt[0] !== x.cnt || ovf[0] !== x.ovf || unf[0] !== x.unf) begin
                errors++;
                $display("FAIL wrap state step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                         i, cnt[0], ovf[0], unf[0], x.cnt, x.ovf, x.unf);
            end
            if (i == 19) begin
                checks++;
                if (cnt[0] !== 4'd4) begin
                    errors++;
                    $display("FAIL wrap after 20 ups: got %0d want 4", cnt[0]);
                end
            end
        end
        checks++;
        if (n_ovf != 1 || n_unf != 1) begin
            errors++;
            $display("FAIL wrap event count: got ovf=%0d unf=%0d want 1 1", n_ovf, n_unf);
        end
    endtask

    // Decade counter never leaves 0..9; an oversized load clamps to 9.
    task automatic test_decade();
        exp_t  x;
        stim_t q [$];
        int    top;
        top = 0;
        for (int i = 0; i < 12; i++) q.push_back(st(0, 0, 1, 1, 4'd0));
        q.push_back(st(0, 1, 1, 0, 4'd13));
        foreach (q[i]) begin
            drive(1, q[i]);
            #1;
            checks++;
            if (tc[1] !== sb[0].tc) begin
                errors++;
                $display("FAIL decade tc step%0d: got %b want %b", i, tc[1], sb[0].tc);
            end
            @(posedge clk); #1;
            x = sb.pop_front();
            if (int'(cnt[1]) > top) top = int'(cnt[1]);
            checks++;
            if (cnt[1] !== x.cnt || ovf[1] !== x.ovf || unf[1] !== x.unf) begin
                errors++;
                $display("FAIL decade state step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                         i, cnt[1], ovf[1], unf[1], x.cnt, x.ovf, x.unf);
            end
        end
        checks++;
        if (cnt[1] !== 4'd9 || top > 9) begin
            errors++;
            $display("FAIL decade clamp: got cnt=%0d max=%0d want cnt=9 max<=9", cnt[1], top);
        end
    endtask

    // Saturating decade counter: repeated boundary hits pulse on consecutive cycles.
    task automatic test_saturate();
        exp_t  x;
        stim_t q [$];
        int    n_ovf, n_unf;
        n_ovf = 0; n_unf = 0;
        q.push_back(st(0, 1, 0, 0, 4'd8));
        for (int i = 0; i < 3; i++) q.push_back(st(0, 0, 1, 1, 4'd0));
        q.push_back(st(0, 1, 0, 0, 4'd1));
        for (int i = 0; i < 3; i++) q.push_back(st(0, 0, 1, 0, 4'd0));
        foreach (q[i]) begin
            drive(2, q[i]);
            #1;
            checks++;
            if (tc[2] !== sb[0].tc) begin
                errors++;
                $display("FAIL saturate tc step%0d: got %b want %b", i, tc[2], sb[0].tc);
            end
            @(posedge clk); #1;
            x = sb.pop_front();
            n_ovf += int'(ovf[2]);
            n_unf += int'(unf[2]);
            checks++;
            if (cnt[2] !== x.cnt || ovf[2] !== x.ovf || unf[2] !== x.unf) begin
                errors++;
                $display("FAIL saturate state step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                         i, cnt[2], ovf[2], unf[2], x.cnt, x.ovf, x.unf);
            end
        end
        checks++;
        if (n_ovf != 2 || n_unf != 2 || cnt[2] !== 4'd0) begin
            errors++;
            $display("FAIL saturate events: got ovf=%0d unf=%0d cnt=%0d want 2 2 0", n_ovf, n_unf, cnt[2]);
        end
    endtask

    // Rst > Ld > E > hold, then a mid-count reset resumes cleanly from zero.
    task automatic test_priority();
        exp_t  x;
        stim_t q [$];
        int    n_evt;
        n_evt = 0;
        q.push_back(st(0, 1, 0, 0, 4'd15));
        q.push_back(st(0, 1, 1, 1, 4'd5));  // load beats the boundary: no Ovf
        q.push_back(st(1, 1, 1, 1, 4'd5));  // reset beats load
        for (int i = 0; i < 3; i++) q.push_back(st(0, 0, 0, 1, 4'd0));
        for (int i = 0; i < 7; i++) q.push_back(st(0, 0, 1, 1, 4'd0));
        q.push_back(st(1, 0, 1, 1, 4'd0));
        for (int i = 0; i < 4; i++) q.push_back(st(0, 0, 1, 1, 4'd0));
        foreach (q[i]) begin
            drive(0, q[i]);
            #1;
            checks++;
            if (tc[0] !== sb[0].tc) begin
                errors++;
                $display("FAIL priority tc step%0d: got %b want %b", i, tc[0], sb[0].tc);
            end
            @(posedge clk); #1;
            x = sb.pop_front();
            n_evt += int'(ovf[0]) + int'(unf[0]);
            checks++;
            if (cnt[0] !== x.cnt || ovf[0] !== x.ovf || unf[0] !== x.unf) begin
                errors++;
                $display("FAIL priority state step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                         i, cnt[0], ovf[0], unf[0], x.cnt, x.ovf, x.unf);
            end
            if (i == 1) begin
                checks++;
                if (cnt[0] !== 4'd5) begin
                    errors++;
                    $display("FAIL priority load: got %0d want 5", cnt[0]);
                end
            end
        end
        checks++;
        if (n_evt != 0 || cnt[0] !== 4'd4) begin
            errors++;
            $display("FAIL mid reset: got events=%0d cnt=%0d want 0 4", n_evt, cnt[0]);
        end
    endtask

    // Random stimulus with direction changes every cycle on all three instances.
    task automatic test_back_to_back();
        exp_t  x;
        stim_t s;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                s = st($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                       (i % 2) == 0, 4'($urandom_range(15)));
                drive(k, s);
                #1;
                checks++;
                if (tc[k] !== sb[0].tc) begin
                    errors++;
                    $display("FAIL b2b tc inst%0d step%0d: got %b want %b", k, i, tc[k], sb[0].tc);
                end
                @(posedge clk); #1;
                x = sb.pop_front();
                checks++;
                if (cnt[k] !== x.cnt || ovf[k] !== x.ovf || unf[k] !== x.unf) begin
                    errors++;
                    $display("FAIL b2b state inst%0d step%0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
                             k, i, cnt[k], ovf[k], unf[k], x.cnt, x.ovf, x.unf);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; e[k] = 1'b0; u[k] = 1'b0; ld[k] = 1'b0; d[k] = 4'd0;
            m_cnt[k] = 0;
        end
        test_reset();
        test_wrap();
        test_decade();
        test_saturate();
        test_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
